apb4_sram_bridge: RTL and testbench

Parametrised APB4-slave to single-port SRAM bridge: successor to the fixed 32-bit / 1-cycle bridge, generalised in data width, address width, depth and SRAM read latency. Adds byte write strobes, range-checked slave error, and back-to-back transfer support. It sits between the APB fabric and any word-addressed on-chip SRAM (coefficient memories, capture buffers).

---
 rtl/apb4_sram_bridge_pkg.sv | 32 +++
 rtl/apb4_sram_bridge_rd_lat_cnt.sv | 37 +++
 rtl/apb4_sram_bridge.sv | 147 ++++++++++++++
 tb/tb_apb4_sram_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_sram_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb4_sram_bridge_pkg
// Shared types and constants for the APB4-to-SRAM bridge:
//   state_t     - bridge FSM state encoding (IDLE = 0)
//   RD_LAT_MAX  - largest supported SRAM read latency
//   clog2()     - ceiling log2, used to size the read-latency counter
//   CNT_W       - read-latency counter width
// ----------------------------------------------------------------------------
package apb4_sram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4,
    ST_WAIT    = 3'd5
  } state_t;

  localparam int RD_LAT_MAX = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Counter holds RD_LAT-1, at most RD_LAT_MAX-1.
  localparam int CNT_W = clog2(RD_LAT_MAX);

endpackage

// File: rtl/apb4_sram_bridge_rd_lat_cnt.sv
// ----------------------------------------------------------------------------
// sram_rd_lat_cnt
// Load/decrement down-counter timing the SRAM read latency.
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset
//   i_load  in   load RD_LAT-1 (issued in the SRAM enable cycle)
//   i_dec   in   decrement, saturating at zero
//   o_zero  out  counter is at terminal count
// ----------------------------------------------------------------------------
module sram_rd_lat_cnt
  import apb4_sram_bridge_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(RD_LAT - 1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/apb4_sram_bridge.sv
// ----------------------------------------------------------------------------
// apb4_sram_bridge
// APB4 slave to single-port, word-addressed SRAM bridge with byte strobes,
// configurable SRAM read latency and optional out-of-range slave error.
// Optional feature macro: APB4_SRAM_BRIDGE_SLVERR_EN
//   defined   - paddr >= DEPTH answers with pslverr and no SRAM access
//   undefined - no error; address wraps modulo 2**ADDR_W
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   psel, penable, pwrite      APB control
//   paddr, pwdata, pstrb       APB word address, write data, byte strobes
//   prdata, pready, pslverr    APB response (prdata is 0 outside pready)
//   addr, en, wr, wdata, wstrb SRAM request (en is a one-cycle pulse)
//   rdata                      SRAM read data, RD_LAT clocks after en
// ----------------------------------------------------------------------------
module apb4_sram_bridge
  import apb4_sram_bridge_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 15,
  parameter int PADDR_W = 16,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int RD_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [PADDR_W-1:0]  paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic [ADDR_W-1:0]   addr,
  output logic                en,
  output logic                wr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_wr;
  logic                r_err;
  logic                r_en;
  logic [DATA_W-1:0]   r_prdata;
  logic                r_pslverr;
  logic                w_err;
  logic                w_cnt_zero;

`ifdef APB4_SRAM_BRIDGE_SLVERR_EN
  // One extra bit so DEPTH = 2**PADDR_W does not truncate to zero.
  assign w_err = ({1'b0, paddr} >= (PADDR_W + 1)'(DEPTH));
`else
  localparam int unused_depth = DEPTH;
  logic w_unused_paddr;
  assign w_unused_paddr = ^paddr;
  assign w_err          = 1'b0;
`endif

  sram_rd_lat_cnt #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == ST_RD),
    .i_dec  (r_state == ST_RD_WAIT),
    .o_zero (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_en      <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      // Setup phase is captured in every state so a back-to-back setup
      // arriving during WAIT is not lost.
      if (psel && !penable) begin
        r_addr  <= paddr[ADDR_W-1:0];
        r_wdata <= pwdata;
        r_wr    <= pwrite;
        r_wstrb <= pwrite ? pstrb : '0;
        r_err   <= w_err;
      end

      r_en <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (psel && penable) begin
            if (r_err) begin
              r_state   <= ST_RESP;
              r_pslverr <= 1'b1;
            end else if (r_wr) begin
              r_state <= ST_WR;
              r_en    <= 1'b1;
            end else begin
              r_state <= ST_RD;
              r_en    <= 1'b1;
            end
          end
        end
        ST_WR:      r_state <= ST_RESP;
        ST_RD:      r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (w_cnt_zero) begin
            r_prdata <= rdata;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!penable) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pready  = (r_state == ST_RESP);
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;
  assign addr    = r_addr;
  assign en      = r_en;
  assign wr      = r_wr;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;

endmodule

// File: tb/tb_apb4_sram_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb4_sram_bridge
// Eight bridges (RD_LAT = 1..8, DEPTH = 1024) share one APB master; each has
// its own SRAM model. Expectations come from a directed vector table plus
// hand-written back-to-back and reset-during-read sequences.
// ----------------------------------------------------------------------------
module tb_apb4_sram_bridge;

  localparam int DEP = 1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic [31:0] prdata_a  [1:8];
  logic        pready_a  [1:8];
  logic        pslverr_a [1:8];
  logic [14:0] addr_a    [1:8];
  logic        en_a      [1:8];
  logic        wr_a      [1:8];
  logic [31:0] wdata_a   [1:8];
  logic [3:0]  wstrb_a   [1:8];
  logic [31:0] rdata_a   [1:8];

  for (genvar g = 1; g <= 8; g++) begin : g_lat
    apb4_sram_bridge #(
      .DATA_W (32), .ADDR_W (15), .PADDR_W (16), .DEPTH (DEP), .RD_LAT (g)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pstrb   (pstrb),
      .prdata  (prdata_a[g]),
      .pready  (pready_a[g]),
      .pslverr (pslverr_a[g]),
      .addr    (addr_a[g]),
      .en      (en_a[g]),
      .wr      (wr_a[g]),
      .wdata   (wdata_a[g]),
      .wstrb   (wstrb_a[g]),
      .rdata   (rdata_a[g])
    );

    // SRAM model: read data valid only in the cycle RD_LAT clocks after en,
    // garbage otherwise so a mistimed capture is visible.
    logic [31:0] mem [0:2047];
    logic [31:0] pd  [0:7];
    logic [7:0]  pv;

    always @(posedge clk) begin
      if (en_a[g] && wr_a[g])
        for (int b = 0; b < 4; b++)
          if (wstrb_a[g][b]) mem[addr_a[g][10:0]][8*b +: 8] <= wdata_a[g][8*b +: 8];
      if (reset) pv <= '0;
      else       pv <= {pv[6:0], en_a[g] & ~wr_a[g]};
      pd[0] <= mem[addr_a[g][10:0]];
      for (int k = 1; k < 8; k++) pd[k] <= pd[k-1];
    end

    assign rdata_a[g] = pv[g-1] ? pd[g-1] : 32'hA5A5_5A5A;
  end

  typedef struct {
    int          li;
    bit          w;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(int li, bit w, logic [15:0] a, logic [31:0] d,
                              logic [3:0] s, logic [31:0] exp_rd, bit exp_err,
                              int exp_lat);
    vec_t v;
    v.li = li; v.w = w; v.a = a; v.d = d; v.s = s;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int li, input string name);
    logic any;
    any = (|prdata_a[li]) | pready_a[li] | pslverr_a[li] | (|addr_a[li]) |
          en_a[li] | wr_a[li] | (|wdata_a[li]) | (|wstrb_a[li]);
    chk(name, any, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 with psel/penable low.
  task automatic run_vec(input vec_t v);
    int          lat, en_cnt, en_cyc;
    bit          err_s, wr_s, pr_leak;
    logic [31:0] rd_s;
    logic [3:0]  strb_s;
    lat = -1; en_cnt = 0; en_cyc = -1; err_s = 0; wr_s = 0; pr_leak = 0;
    rd_s = '0; strb_s = '0;
    psel = 1'b1; penable = 1'b0; pwrite = v.w; paddr = v.a; pwdata = v.d; pstrb = v.s;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (en_a[v.li]) begin
        en_cnt++;
        if (en_cyc < 0) en_cyc = c;
        strb_s = wstrb_a[v.li];
        wr_s   = wr_a[v.li];
      end
      if (pready_a[v.li]) begin
        lat   = c;
        rd_s  = prdata_a[v.li];
        err_s = pslverr_a[v.li];
      end else if (prdata_a[v.li] != 32'h0) begin
        pr_leak = 1'b1;
      end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    psel = 1'b0; penable = 1'b0;
    chk("pready_cycle", lat, v.exp_lat);
    chk("pslverr", err_s, v.exp_err);
    if (!v.w) chk("prdata", rd_s, v.exp_rd);
    chk("en_pulses", en_cnt, v.exp_err ? 0 : 1);
    if (!v.exp_err) begin
      chk("en_cycle", en_cyc, 1);
      chk("wr_at_en", wr_s, v.w);
      chk("wstrb_at_en", strb_s, v.w ? v.s : 4'h0);
    end
    chk("prdata_zero_outside_pready", pr_leak, 0);
  endtask

  initial begin
    int en_seen;

    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int li = 1; li <= 8; li++) chk_zero(li, "reset_outputs");
    @(posedge clk); #1;

    vecs.push_back(mk(1, 1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 2));
    vecs.push_back(mk(1, 0, 16'h0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, 3));
    vecs.push_back(mk(1, 1, 16'h0020, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 2));
    vecs.push_back(mk(1, 1, 16'h0020, 32'h1122_3344, 4'h5, 32'h0, 0, 2));
    vecs.push_back(mk(1, 0, 16'h0020, 32'h0,         4'h0, 32'hFF22_FF44, 0, 3));
    vecs.push_back(mk(1, 1, 16'h0003, 32'hC0FF_EE03, 4'hF, 32'h0, 0, 2));
    for (int l = 1; l <= 8; l++)
      vecs.push_back(mk(l, 0, 16'h0003, 32'h0, 4'h0, 32'hC0FF_EE03, 0, 2 + l));
    vecs.push_back(mk(1, 1, 16'h03FF, 32'h5A5A_00FF, 4'hF, 32'h0, 0, 2));
    vecs.push_back(mk(1, 0, 16'h03FF, 32'h0,         4'h0, 32'h5A5A_00FF, 0, 3));
`ifdef APB4_SRAM_BRIDGE_SLVERR_EN
    vecs.push_back(mk(1, 0, 16'h0400, 32'h0,         4'h0, 32'h0, 1, 1));
    vecs.push_back(mk(1, 1, 16'h0400, 32'h0BAD_0400, 4'hF, 32'h0, 1, 1));
    vecs.push_back(mk(4, 0, 16'h8010, 32'h0,         4'h0, 32'h0, 1, 1));
`else
    vecs.push_back(mk(1, 1, 16'h0400, 32'h0BAD_0400, 4'hF, 32'h0, 0, 2));
    vecs.push_back(mk(1, 0, 16'h0400, 32'h0,         4'h0, 32'h0BAD_0400, 0, 3));
    vecs.push_back(mk(4, 0, 16'h8010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, 6));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
      idle(12);
    end

    // Back-to-back on the RD_LAT=1 bridge: next setup lands in the WAIT cycle.
    for (int i = 0; i < 4; i++) begin
      run_vec(mk(1, 1, 16'h0040 + 16'(i), 32'h0B0B_0000 | 32'(i * 17), 4'hF, 32'h0, 0, 2));
      run_vec(mk(1, 0, 16'h0040 + 16'(i), 32'h0, 4'h0, 32'h0B0B_0000 | 32'(i * 17), 0, 3));
    end

    // Resynchronise the slower bridges disturbed by the back-to-back burst.
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Reset during RD_WAIT on the RD_LAT=3 bridge.
    run_vec(mk(3, 1, 16'h0050, 32'h7777_5050, 4'hF, 32'h0, 0, 2));
    idle(12);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0050;
    @(posedge clk); #1;
    penable = 1'b1;                 // cycle 0
    @(posedge clk); #1;             // cycle 1: RD
    @(posedge clk); #1;             // cycle 2: RD_WAIT
    reset = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero(3, "reset_mid_read_outputs");
    en_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (en_a[3] || pready_a[3]) en_seen++;
    end
    chk("reset_mid_read_no_restart", en_seen, 0);
    @(posedge clk); #1;
    run_vec(mk(3, 0, 16'h0050, 32'h0, 4'h0, 32'h7777_5050, 0, 5));
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
